gpc_pipe: RTL and testbench

//   Parametrised, pipelined generalised parallel counter (GPC) with a valid/ready stream interface
//   and an optional group-accumulate mode. Column i holds Ki bits of weight 2^i (i = 0..2).
//   dst = popcount(src0) + 2*popcount(src1) + 4*popcount(src2). Defaults give the (3,1,1;4) counter.

---
 rtl/gpc_pipe_if.sv | 32 +++
 rtl/gpc_pipe.sv | 148 ++++++++++++++
 tb/tb_gpc_pipe.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpc_pipe_if.sv
// Stream bundle for gpc_pipe: input beat channel plus registered result channel.
// A beat moves on a channel only in a cycle where its valid and ready are both high; valid may not wait on ready.
interface gpc_pipe_if #(
  parameter int K0    = 1,
  parameter int K1    = 1,
  parameter int K2    = 3,
  parameter int OUT_W = 4,
  parameter int ACC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [K0-1:0]    src0;
  logic [K1-1:0]    src1;
  logic [K2-1:0]    src2;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] dst;
  logic [ACC_W-1:0] acc;
  logic             acc_ovf;
  logic             out_last;

  modport master (
    output in_valid, src0, src1, src2, in_last, out_ready,
    input  in_ready, out_valid, dst, acc, acc_ovf, out_last
  );

  modport slave (
    input  in_valid, src0, src1, src2, in_last, out_ready,
    output in_ready, out_valid, dst, acc, acc_ovf, out_last
  );
endinterface

// File: rtl/gpc_pipe.sv
// Pipelined generalised parallel counter: dst = pc(src0) + 2*pc(src1) + 4*pc(src2),
// with a per-group running total. STAGES selects a 1- or 2-register pipeline.
module gpc_pipe #(
  parameter int K0     = 1,
  parameter int K1     = 1,
  parameter int K2     = 3,
  parameter int OUT_W  = 4,
  parameter int ACC_W  = 8,
  parameter int STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  gpc_pipe_if.slave bus
);
  localparam int C0_W = $clog2(K0 + 1);
  localparam int C1_W = $clog2(K1 + 1);
  localparam int C2_W = $clog2(K2 + 1);

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("gpc_pipe: STAGES must be 1 or 2");
  end
  if (((1 << OUT_W) - 1) < (K0 + 2 * K1 + 4 * K2)) begin : g_bad_out_w
    $error("gpc_pipe: OUT_W too narrow for the maximum weighted sum");
  end
  if (ACC_W < OUT_W || K0 < 1 || K1 < 1 || K2 < 1) begin : g_bad_widths
    $error("gpc_pipe: ACC_W must be >= OUT_W and every column needs at least one bit");
  end

  logic [C0_W-1:0] w_pc0;
  logic [C1_W-1:0] w_pc1;
  logic [C2_W-1:0] w_pc2;

  always_comb begin
    w_pc0 = '0;
    for (int i = 0; i < K0; i++) w_pc0 = w_pc0 + C0_W'(bus.src0[i]);
  end

  always_comb begin
    w_pc1 = '0;
    for (int i = 0; i < K1; i++) w_pc1 = w_pc1 + C1_W'(bus.src1[i]);
  end

  always_comb begin
    w_pc2 = '0;
    for (int i = 0; i < K2; i++) w_pc2 = w_pc2 + C2_W'(bus.src2[i]);
  end

  logic             r_out_valid;
  logic [OUT_W-1:0] r_dst;
  logic [ACC_W-1:0] r_acc;
  logic             r_acc_ovf;
  logic             r_out_last;
  logic             r_group_start;

  logic             w_in_ready;
  logic             w_fin_room;
  logic             w_fin_valid;
  logic             w_fin_load;
  logic [C0_W-1:0]  w_fin_c0;
  logic [C1_W-1:0]  w_fin_c1;
  logic [C2_W-1:0]  w_fin_c2;
  logic             w_fin_last;

  // The final stage may load when it is empty or its beat leaves this cycle.
  assign w_fin_room = !r_out_valid || bus.out_ready;
  assign w_fin_load = w_fin_room && w_fin_valid;

  if (STAGES == 2) begin : g_two
    logic            r_s1_valid;
    logic [C0_W-1:0] r_c0;
    logic [C1_W-1:0] r_c1;
    logic [C2_W-1:0] r_c2;
    logic            r_s1_last;

    assign w_in_ready  = !r_s1_valid || w_fin_room;
    assign w_fin_valid = r_s1_valid;
    assign w_fin_c0    = r_c0;
    assign w_fin_c1    = r_c1;
    assign w_fin_c2    = r_c2;
    assign w_fin_last  = r_s1_last;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1_valid <= 1'b0;
        r_c0       <= '0;
        r_c1       <= '0;
        r_c2       <= '0;
        r_s1_last  <= 1'b0;
      end else if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_c0      <= w_pc0;
          r_c1      <= w_pc1;
          r_c2      <= w_pc2;
          r_s1_last <= bus.in_last;
        end
      end
    end
  end else begin : g_one
    assign w_in_ready  = w_fin_room;
    assign w_fin_valid = bus.in_valid;
    assign w_fin_c0    = w_pc0;
    assign w_fin_c1    = w_pc1;
    assign w_fin_c2    = w_pc2;
    assign w_fin_last  = bus.in_last;
  end

  logic [OUT_W-1:0] w_dst;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf_base;

  assign w_dst      = OUT_W'(w_fin_c0) + (OUT_W'(w_fin_c1) << 1) + (OUT_W'(w_fin_c2) << 2);
  assign w_base     = r_group_start ? '0 : r_acc;
  assign w_ovf_base = r_group_start ? 1'b0 : r_acc_ovf;
  // One extra bit so the carry-out of the group total is visible as the wrap flag.
  assign w_sum      = {1'b0, w_base} + (ACC_W + 1)'(w_dst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_dst         <= '0;
      r_acc         <= '0;
      r_acc_ovf     <= 1'b0;
      r_out_last    <= 1'b0;
      r_group_start <= 1'b1;
    end else if (w_fin_room) begin
      r_out_valid <= w_fin_valid;
      if (w_fin_valid) begin
        r_dst         <= w_dst;
        r_acc         <= w_sum[ACC_W-1:0];
        r_acc_ovf     <= w_ovf_base | w_sum[ACC_W];
        r_out_last    <= w_fin_last;
        r_group_start <= w_fin_last;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.dst       = r_dst;
  assign bus.acc       = r_acc;
  assign bus.acc_ovf   = r_acc_ovf;
  assign bus.out_last  = r_out_last;

  logic w_unused;
  assign w_unused = w_fin_load;
endmodule

// File: tb/tb_gpc_pipe.sv
// Bench for gpc_pipe: default (3,1,1;4) pipe, a narrow-accumulator copy and a
// single-stage (2,2,3) copy, driven one at a time through a shared cycle task.
module tb_gpc_pipe;
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gpc_pipe_if #(.K0(1), .K1(1), .K2(3), .OUT_W(4), .ACC_W(8)) if_a ();
  gpc_pipe_if #(.K0(1), .K1(1), .K2(3), .OUT_W(4), .ACC_W(5)) if_b ();
  gpc_pipe_if #(.K0(3), .K1(2), .K2(2), .OUT_W(4), .ACC_W(8)) if_c ();

  gpc_pipe #(.K0(1), .K1(1), .K2(3), .OUT_W(4), .ACC_W(8), .STAGES(2))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  gpc_pipe #(.K0(1), .K1(1), .K2(3), .OUT_W(4), .ACC_W(5), .STAGES(2))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  gpc_pipe #(.K0(3), .K1(2), .K2(2), .OUT_W(4), .ACC_W(8), .STAGES(1))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  logic       drv_valid [3];
  logic [2:0] drv_s0    [3];
  logic [2:0] drv_s1    [3];
  logic [2:0] drv_s2    [3];
  logic       drv_last  [3];
  logic       drv_ordy  [3];

  assign if_a.in_valid = drv_valid[0];
  assign if_a.src0     = drv_s0[0][0:0];
  assign if_a.src1     = drv_s1[0][0:0];
  assign if_a.src2     = drv_s2[0];
  assign if_a.in_last  = drv_last[0];
  assign if_a.out_ready = drv_ordy[0];

  assign if_b.in_valid = drv_valid[1];
  assign if_b.src0     = drv_s0[1][0:0];
  assign if_b.src1     = drv_s1[1][0:0];
  assign if_b.src2     = drv_s2[1];
  assign if_b.in_last  = drv_last[1];
  assign if_b.out_ready = drv_ordy[1];

  assign if_c.in_valid = drv_valid[2];
  assign if_c.src0     = drv_s0[2];
  assign if_c.src1     = drv_s1[2][1:0];
  assign if_c.src2     = drv_s2[2][1:0];
  assign if_c.in_last  = drv_last[2];
  assign if_c.out_ready = drv_ordy[2];

  // Packed monitor word: {out_last, acc_ovf, acc[7:0], dst[3:0]}
  logic        mon_in_ready  [3];
  logic        mon_out_valid [3];
  logic [13:0] mon_pack      [3];

  assign mon_in_ready[0]  = if_a.in_ready;
  assign mon_out_valid[0] = if_a.out_valid;
  assign mon_pack[0]      = {if_a.out_last, if_a.acc_ovf, if_a.acc, if_a.dst};
  assign mon_in_ready[1]  = if_b.in_ready;
  assign mon_out_valid[1] = if_b.out_valid;
  assign mon_pack[1]      = {if_b.out_last, if_b.acc_ovf, 3'b000, if_b.acc, if_b.dst};
  assign mon_in_ready[2]  = if_c.in_ready;
  assign mon_out_valid[2] = if_c.out_valid;
  assign mon_pack[2]      = {if_c.out_last, if_c.acc_ovf, if_c.acc, if_c.dst};

  int n_checks = 0;
  int n_err    = 0;
  logic [13:0] exp_q[$];

  typedef struct {
    logic [2:0] s0;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [3:0] exp_dst;
  } vec_t;
  vec_t tbl [32];

  // Reference model for the random phase (8-bit accumulator).
  logic       m_gs;
  logic [7:0] m_acc;
  logic       m_ovf;

  function automatic logic [13:0] pk(input int d, input int a, input int o, input int l);
    return {l[0], o[0], a[7:0], d[3:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int idx, input logic v, input logic [2:0] s0, input logic [2:0] s1,
                        input logic [2:0] s2, input logic last, input logic ordy);
    drv_valid[idx] = v;
    drv_s0[idx]    = s0;
    drv_s1[idx]    = s1;
    drv_s2[idx]    = s2;
    drv_last[idx]  = last;
    drv_ordy[idx]  = ordy;
  endtask

  // One clock of a scoreboarded run: drive, settle, score any output transfer, advance.
  task automatic cyc(input int idx, input logic v, input logic [2:0] s0, input logic [2:0] s1,
                     input logic [2:0] s2, input logic last, input logic ordy, output logic took);
    logic [13:0] e;
    set_in(idx, v, s0, s1, s2, last, ordy);
    #2;
    took = v && mon_in_ready[idx];
    if (mon_out_valid[idx] && ordy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_out: got 0x%0h expected none", mon_pack[idx]);
      end else begin
        e = exp_q.pop_front();
        chk("out_beat", {18'd0, mon_pack[idx]}, {18'd0, e});
      end
    end
    tick();
  endtask

  task automatic model_push(input logic [2:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                            input logic last);
    int d;
    logic [8:0] sum;
    logic [7:0] base;
    d    = $countones(s0) + 2 * $countones(s1) + 4 * $countones(s2);
    base = m_gs ? 8'd0 : m_acc;
    sum  = {1'b0, base} + 9'(d);
    m_ovf = (m_gs ? 1'b0 : m_ovf) | sum[8];
    m_acc = sum[7:0];
    m_gs  = last;
    exp_q.push_back(pk(d, int'(m_acc), int'(m_ovf), int'(last)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic took;
    int   acc_n;
    logic [2:0] r0;
    logic [1:0] r1, r2;
    logic rl, rv, ro;

    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    for (int p = 0; p < 32; p++) begin
      tbl[p].s0      = {2'b00, p[0]};
      tbl[p].s1      = {2'b00, p[1]};
      tbl[p].s2      = p[4:2];
      tbl[p].exp_dst = 4'(p[0] + 2 * p[1] + 4 * (p[2] + p[3] + p[4]));
    end

    // Reset state of all three instances
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", {31'd0, mon_out_valid[i]}, 0);
      chk("rst_outputs", {18'd0, mon_pack[i]}, 0);
      chk("rst_in_ready", {31'd0, mon_in_ready[i]}, 1);
    end
    rst = 1'b0;
    tick();

    // 1: all 32 patterns back-to-back, one-beat groups, 2-cycle latency
    for (int c = 0; c < 34; c++) begin
      if (c < 32) set_in(0, 1'b1, tbl[c].s0, tbl[c].s1, tbl[c].s2, 1'b1, 1'b1);
      else        set_in(0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
      #2;
      if (c < 32) chk("t1_in_ready", {31'd0, mon_in_ready[0]}, 1);
      if (c >= 2) begin
        chk("t1_out_valid", {31'd0, mon_out_valid[0]}, 1);
        chk("t1_dst", {28'd0, mon_pack[0][3:0]}, {28'd0, tbl[c-2].exp_dst});
        chk("t1_acc", {24'd0, mon_pack[0][11:4]}, {28'd0, tbl[c-2].exp_dst});
        chk("t1_last", {31'd0, mon_pack[0][13]}, 1);
      end else begin
        chk("t1_out_valid_early", {31'd0, mon_out_valid[0]}, 0);
      end
      tick();
    end
    chk("t1_out_valid_after", {31'd0, mon_out_valid[0]}, 0);

    // 2: output stalled for 4 cycles with three beats offered (sums 1, 2, 4)
    exp_q.push_back(pk(1, 1, 0, 1));
    exp_q.push_back(pk(2, 2, 0, 1));
    exp_q.push_back(pk(4, 4, 0, 1));
    cyc(0, 1'b1, 3'd1, 3'd0, 3'd0, 1'b1, 1'b0, took);
    chk("t2_take_a", {31'd0, took}, 1);
    cyc(0, 1'b1, 3'd0, 3'd1, 3'd0, 1'b1, 1'b0, took);
    chk("t2_take_b", {31'd0, took}, 1);
    for (int k = 0; k < 2; k++) begin
      chk("t2_hold_valid", {31'd0, mon_out_valid[0]}, 1);
      chk("t2_hold_data", {18'd0, mon_pack[0]}, {18'd0, pk(1, 1, 0, 1)});
      cyc(0, 1'b1, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, took);
      chk("t2_stall_ready", {31'd0, took}, 0);
    end
    chk("t2_hold_data2", {18'd0, mon_pack[0]}, {18'd0, pk(1, 1, 0, 1)});
    cyc(0, 1'b1, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, took);
    chk("t2_take_c", {31'd0, took}, 1);
    for (int k = 0; k < 4; k++) cyc(0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, took);
    chk("t2_q_empty", exp_q.size(), 0);

    // 3: group of 15,15,15 with an ignored idle in_last in the middle, then a new group of 5
    exp_q.push_back(pk(15, 15, 0, 0));
    exp_q.push_back(pk(15, 30, 0, 0));
    exp_q.push_back(pk(15, 45, 0, 1));
    exp_q.push_back(pk(5, 5, 0, 1));
    cyc(0, 1'b1, 3'd1, 3'd1, 3'd7, 1'b0, 1'b1, took);
    chk("t3_take", {31'd0, took}, 1);
    cyc(0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, took);
    cyc(0, 1'b1, 3'd1, 3'd1, 3'd7, 1'b0, 1'b1, took);
    chk("t3_take", {31'd0, took}, 1);
    cyc(0, 1'b1, 3'd1, 3'd1, 3'd7, 1'b1, 1'b1, took);
    chk("t3_take", {31'd0, took}, 1);
    cyc(0, 1'b1, 3'd1, 3'd0, 3'd1, 1'b1, 1'b1, took);
    chk("t3_take", {31'd0, took}, 1);
    for (int k = 0; k < 4; k++) cyc(0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, took);
    chk("t3_q_empty", exp_q.size(), 0);

    // 4: 5-bit accumulator wraps on the third beat, next group clears the flag
    exp_q.push_back(pk(15, 15, 0, 0));
    exp_q.push_back(pk(15, 30, 0, 0));
    exp_q.push_back(pk(15, 13, 1, 1));
    exp_q.push_back(pk(1, 1, 0, 1));
    cyc(1, 1'b1, 3'd1, 3'd1, 3'd7, 1'b0, 1'b1, took);
    cyc(1, 1'b1, 3'd1, 3'd1, 3'd7, 1'b0, 1'b1, took);
    cyc(1, 1'b1, 3'd1, 3'd1, 3'd7, 1'b1, 1'b1, took);
    cyc(1, 1'b1, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1, took);
    chk("t4_take", {31'd0, took}, 1);
    for (int k = 0; k < 4; k++) cyc(1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, took);
    chk("t4_q_empty", exp_q.size(), 0);

    // 5: asynchronous reset mid-cycle with beats in flight
    set_in(0, 1'b1, 3'd1, 3'd1, 3'd7, 1'b0, 1'b1);
    tick();
    set_in(0, 1'b1, 3'd1, 3'd1, 3'd7, 1'b0, 1'b1);
    tick();
    set_in(0, 1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1);
    tick();
    set_in(0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    #2;
    chk("t5_pre_valid", {31'd0, mon_out_valid[0]}, 1);
    chk("t5_pre_acc", {24'd0, mon_pack[0][11:4]}, 30);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, mon_out_valid[0]}, 0);
    chk("t5_rst_outputs", {18'd0, mon_pack[0]}, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_flushed", {31'd0, mon_out_valid[0]}, 0);
    end
    set_in(0, 1'b1, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1);
    tick();
    set_in(0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("t5_post_valid", {31'd0, mon_out_valid[0]}, 1);
    chk("t5_post_beat", {18'd0, mon_pack[0]}, {18'd0, pk(4, 4, 0, 1)});
    tick();
    chk("t5_post_single", {31'd0, mon_out_valid[0]}, 0);

    // 6: single-stage (2,2,3) counter, all-ones with 1-cycle latency, then random traffic
    set_in(2, 1'b1, 3'd7, 3'd3, 3'd3, 1'b1, 1'b1);
    #2;
    chk("t6_lat_before", {31'd0, mon_out_valid[2]}, 0);
    tick();
    set_in(2, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    #2;
    chk("t6_lat_valid", {31'd0, mon_out_valid[2]}, 1);
    chk("t6_all_ones", {18'd0, mon_pack[2]}, {18'd0, pk(15, 15, 0, 1)});
    tick();
    chk("t6_lat_after", {31'd0, mon_out_valid[2]}, 0);

    m_gs  = 1'b1;
    m_acc = 8'd0;
    m_ovf = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 3000 && acc_n < 200; i++) begin
      r0 = 3'($urandom_range(0, 7));
      r1 = 2'($urandom_range(0, 3));
      r2 = 2'($urandom_range(0, 3));
      rl = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 3) != 0);
      ro = ($urandom_range(0, 1) == 1);
      cyc(2, rv, r0, {1'b0, r1}, {1'b0, r2}, rl, ro, took);
      if (took) begin
        model_push(r0, r1, r2, rl);
        acc_n++;
      end
    end
    chk("t6_accepted", acc_n, 200);
    for (int k = 0; k < 10; k++) cyc(2, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, took);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
